mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified memory between the instruction-fetch stage and the MEM-stage load/store path of the MIPS pipeline. Performs per-requester arbitration, issues one access at a time, generates byte enables and sign extension for byte/half/word accesses, and drives per-requester stall signals back into the pipeline. Data accesses take priority, and a streak limiter prevents fetch starvation.

## Interface
- MEM_LAT, 2: cycles from the ISSUE cycle to valid MemRdata; legal 1..4
- STARVE_MAX, 4: consecutive data grants allowed while IReq is pending before fetch is forced; legal 1..15
- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  reset, synchronous, active-high
- IReq  in  1  fetch request; level, held until IValid
- IAddr  in  32  fetch address; word-aligned, stable while IReq=1
- IRdata  out  32  fetched instruction; valid when IValid=1
- IValid  out  1  one-cycle completion pulse for fetch
- IStall  out  1  IReq & ~IValid (combinational)
- DReq  in  1  data request; level, held until DValid
- DWe  in  1  1 = store, 0 = load
- DSize  in  2  00 byte, 01 half, 10 word; 11 treated as word
- DAddr  in  32  byte address
- DWdata  in  32  store data, right-justified
- DRdata  out  32  load data, sign-extended for byte/half
- DValid  out  1  one-cycle completion pulse for data
- DErr  out  1  pulses together with DValid on a misaligned access
- DStall  out  1  DReq & ~DValid (combinational)
- MemEn  out  1  memory access strobe, high for exactly one cycle per access
- MemWe  out  1  write strobe, qualified by MemEn
- MemByteEn  out  4  byte lanes for writes; 1111 on reads
- MemAddr  out  32  word address {addr[31:2],2'b00}
- MemWdata  out  32  lane-aligned store data
- MemRdata  in  32  read data, valid MEM_LAT cycles after MemEn

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: evaluates requests each cycle.
  - If DReq=1 and (IReq=0 or streak<STARVE_MAX), grant D.
  - Otherwise, if IReq=1, grant I.
  - On a grant, register owner, address, size, we and wdata, then go to ISSUE.
  - With no request, stay in IDLE.
- Misaligned D (half with addr[0]=1, or word with addr[1:0]≠0): no memory access; go straight to DONE with DErr=1.
- ISSUE: MemEn=1 and MemAddr/MemWe/MemByteEn/MemWdata are driven from registered values. Writes go to DONE; reads go to WAIT and load the latency counter.
- WAIT: lasts MEM_LAT cycles. On its last cycle, capture MemRdata (extracted and extended for D), then go to DONE.
- DONE: pulse the owner's Valid (and DErr if flagged), then go to IDLE. Requests seen in the DONE cycle are not arbitrated, so a requester is never served twice on a stale Req.
- Byte lanes:
  - Byte: ByteEn = 0001<<addr[1:0]; Wdata = {4{DWdata[7:0]}}.
  - Half: ByteEn = addr[1] ? 1100 : 0011; Wdata = {2{DWdata[15:0]}}.
  - Word: ByteEn = 1111.
- Load extraction: select the byte or half by addr[1:0] and sign-extend it to 32 bits.
- Streak counter (4-bit):
  - +1 on each D grant while IReq=1.
  - Cleared on an I grant, or when IReq=0 in IDLE.
  - Saturates at STARVE_MAX.
- IRdata/DRdata hold their last captured value until the next capture for that requester.

## Timing
- Reset: state IDLE, streak 0. IRdata, IValid, DRdata, DValid, DErr, MemEn, MemWe, MemAddr and MemWdata are 0, and MemByteEn is 0000. IStall/DStall follow their combinational equations.
- Requests are accepted in the IDLE cycle t (the cycle where IDLE sees the request).
- Read: ISSUE at t+1, capture at t+1+MEM_LAT, Valid at t+2+MEM_LAT (t+4 for MEM_LAT=2).
- Write: ISSUE at t+1, Valid at t+2.
- Misaligned: Valid+DErr at t+1, MemEn never asserted.
- Simultaneous IReq/DReq in IDLE: D wins unless streak==STARVE_MAX.
- Rst during ISSUE/WAIT/DONE: FSM returns to IDLE on the next edge with no Valid pulse, and in-flight read data is discarded.
- Req dropped mid-transaction is a protocol violation: the access completes and Valid still pulses.

## Test plan
- Single fetch, MEM_LAT=2: IReq at cycle 0, memory returns 0x8C220004 → MemEn high in cycle 1 only, IValid at cycle 4 with IRdata=0x8C220004, IStall high cycles 0-3.
- Store byte: DWe=1, DSize=00, DAddr=0x103, DWdata=0xAB → MemAddr=0x100, MemByteEn=1000, MemWdata=0xABABABAB, DValid at cycle 2.
- Load half sign-extend: DSize=01, DAddr=0x202, MemRdata=0x8001_1234 → DRdata=0xFFFF8001. Same access with DAddr=0x200 → DRdata=0x00001234.
- Misaligned word: DAddr=0x302, DSize=10 → no MemEn, DValid=DErr=1 at cycle 1.
- Contention, STARVE_MAX=4: IReq and DReq held continuously → grant order D,D,D,D,I,D,D,D,D,I.
- Reset mid-read: assert Rst in the WAIT cycle → no IValid/DValid, FSM in IDLE, all outputs at reset values, and the next request completes with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IValid,
  output logic        IStall,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [1:0]  DSize,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DValid,
  output logic        DErr,
  output logic        DStall,
  output logic        MemEn,
  output logic        MemWe,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic        own_d_q, own_d_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [3:0]  streak_q, streak_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;

  logic        misalign;
  logic        grant_d;
  logic        grant_i;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      own_d_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
      lat_q    <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      own_d_q  <= own_d_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      streak_q <= streak_d;
      lat_q    <= lat_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  // Load extraction works on the registered address of the in-flight access.
  always_comb begin
    rd_byte = MemRdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half = addr_q[1] ? MemRdata[31:16] : MemRdata[15:0];
    case (size_q)
      2'b00:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{rd_half[15]}}, rd_half};
      default: rd_ext = MemRdata;
    endcase
  end

  always_comb begin
    misalign = ((DSize == 2'b01) && DAddr[0]) || (DSize[1] && (DAddr[1:0] != 2'b00));
    grant_d  = DReq && (!IReq || (streak_q < STREAK_MAX));
    grant_i  = !grant_d && IReq;
  end

  always_comb begin
    state_d  = state_q;
    own_d_d  = own_d_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    streak_d = streak_q;
    lat_d    = lat_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    case (state_q)
      IDLE: begin
        if (!IReq) streak_d = '0;
        if (grant_d) begin
          own_d_d = 1'b1;
          addr_d  = DAddr;
          size_d  = DSize;
          we_d    = DWe;
          wdata_d = DWdata;
          err_d   = misalign;
          if (IReq && (streak_q < STREAK_MAX)) streak_d = streak_q + 4'd1;
          state_d = misalign ? DONE : ISSUE;
        end else if (grant_i) begin
          own_d_d  = 1'b0;
          addr_d   = IAddr;
          size_d   = 2'b10;
          we_d     = 1'b0;
          wdata_d  = '0;
          err_d    = 1'b0;
          streak_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == 3'd0) begin
          if (own_d_q) drdata_d = rd_ext;
          else         irdata_d = MemRdata;
          state_d = DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes are only non-zero in ISSUE so they read as zero at reset and while idle.
  always_comb begin
    MemEn     = 1'b0;
    MemWe     = 1'b0;
    MemByteEn = 4'b0000;
    MemAddr   = '0;
    MemWdata  = '0;
    if (state_q == ISSUE) begin
      MemEn   = 1'b1;
      MemWe   = we_q;
      MemAddr = {addr_q[31:2], 2'b00};
      if (!we_q) begin
        MemByteEn = 4'b1111;
      end else begin
        case (size_q)
          2'b00: begin
            MemByteEn = 4'b0001 << addr_q[1:0];
            MemWdata  = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            MemByteEn = addr_q[1] ? 4'b1100 : 4'b0011;
            MemWdata  = {2{wdata_q[15:0]}};
          end
          default: begin
            MemByteEn = 4'b1111;
            MemWdata  = wdata_q;
          end
        endcase
      end
    end
  end

  assign IValid = (state_q == DONE) && !own_d_q;
  assign DValid = (state_q == DONE) && own_d_q;
  assign DErr   = DValid && err_q;
  assign IRdata = irdata_q;
  assign DRdata = drdata_q;
  assign IStall = IReq & ~IValid;
  assign DStall = DReq & ~DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IRdata;
  logic        IValid;
  logic        IStall;
  logic        DReq;
  logic        DWe;
  logic [1:0]  DSize;
  logic [31:0] DAddr;
  logic [31:0] DWdata;
  logic [31:0] DRdata;
  logic        DValid;
  logic        DErr;
  logic        DStall;
  logic        MemEn;
  logic        MemWe;
  logic [3:0]  MemByteEn;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .Clk(Clk), .Rst(Rst),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IValid(IValid), .IStall(IStall),
    .DReq(DReq), .DWe(DWe), .DSize(DSize), .DAddr(DAddr), .DWdata(DWdata),
    .DRdata(DRdata), .DValid(DValid), .DErr(DErr), .DStall(DStall),
    .MemEn(MemEn), .MemWe(MemWe), .MemByteEn(MemByteEn), .MemAddr(MemAddr),
    .MemWdata(MemWdata), .MemRdata(MemRdata)
  );

  always #5 Clk = ~Clk;

  // Memory model: read data appears MEM_LAT cycles after the MemEn cycle.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pipe [0:MEM_LAT-1];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge Clk) begin
    pipe[0] <= (MemEn && !MemWe) ? rd_word(MemAddr) : 32'hDEAD_BEEF;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign MemRdata = pipe[MEM_LAT-1];

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    bit          chk_rd;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge with the FSM idle; the request cycle is cycle 0.
  task automatic run_access(input string tag, input bit is_d, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input bit exp_err,
                            input logic [3:0] exp_be, input logic [31:0] exp_mwd, input int exp_lat);
    exp_t e;
    exp_t got;
    int   n_en;
    bit   done;
    e.is_d   = is_d;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    e.chk_rd = !we && !exp_err;
    sb.push_back(e);
    if (is_d) begin
      DReq = 1'b1; DWe = we; DSize = size; DAddr = addr; DWdata = wdata;
    end else begin
      IReq = 1'b1; IAddr = addr;
    end
    #1;
    chk({tag, ".stall0"}, is_d ? DStall : IStall, 1'b1);
    n_en = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
      @(negedge Clk);
      if (MemEn) n_en++;
      if (cyc == 1 && !exp_err) begin
        chk({tag, ".memen"}, MemEn, 1'b1);
        chk({tag, ".memaddr"}, MemAddr, {addr[31:2], 2'b00});
        chk({tag, ".memwe"}, MemWe, we);
        chk({tag, ".byteen"}, MemByteEn, exp_be);
        if (we) chk({tag, ".memwdata"}, MemWdata, exp_mwd);
      end
      if (is_d ? DValid : IValid) begin
        done = 1'b1;
        got = sb.pop_front();
        chk({tag, ".latency"}, cyc, exp_lat);
        chk({tag, ".owner"}, {31'd0, DValid}, {31'd0, got.is_d});
        chk({tag, ".derr"}, DErr, got.err);
        chk({tag, ".stall_at_valid"}, is_d ? DStall : IStall, 1'b0);
        chk({tag, ".memen_count"}, n_en, exp_err ? 0 : 1);
        if (got.chk_rd) chk({tag, ".rdata"}, got.is_d ? DRdata : IRdata, got.rdata);
        DReq = 1'b0;
        IReq = 1'b0;
      end else begin
        chk({tag, ".stall"}, is_d ? DStall : IStall, 1'b1);
      end
    end
    if (!done) begin
      chk({tag, ".timeout"}, {31'd0, done}, 32'd1);
      void'(sb.pop_front());
      DReq = 1'b0;
      IReq = 1'b0;
    end
    @(negedge Clk);
    chk({tag, ".valid_one_cycle"}, {30'd0, IValid, DValid}, 32'd0);
  endtask

  bit   grant_is_d [0:9];
  int   g;
  int   n_valid;

  initial begin
    mem[32'h0000_0040] = 32'h8C22_0004;
    mem[32'h0000_0200] = 32'h8001_1234;
    Rst = 1'b1;
    IReq = 1'b0; IAddr = '0;
    DReq = 1'b0; DWe = 1'b0; DSize = 2'b00; DAddr = '0; DWdata = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("reset.outs", {IValid, DValid, DErr, MemEn, MemWe, IStall, DStall}, 7'd0);
    chk("reset.byteen", MemByteEn, 4'b0000);
    chk("reset.memaddr", MemAddr, 32'd0);
    chk("reset.memwdata", MemWdata, 32'd0);
    chk("reset.irdata", IRdata, 32'd0);
    chk("reset.drdata", DRdata, 32'd0);

    run_access("fetch",   1'b0, 1'b0, 2'b10, 32'h40,  32'h0,        32'h8C22_0004, 1'b0, 4'b1111, 32'h0, 4);
    run_access("st_b",    1'b1, 1'b1, 2'b00, 32'h103, 32'hAB,       32'h0,         1'b0, 4'b1000, 32'hABAB_ABAB, 2);
    run_access("st_h",    1'b1, 1'b1, 2'b01, 32'h102, 32'h1234_CDEF, 32'h0,        1'b0, 4'b1100, 32'hCDEF_CDEF, 2);
    run_access("st_w",    1'b1, 1'b1, 2'b10, 32'h104, 32'h1122_3344, 32'h0,        1'b0, 4'b1111, 32'h1122_3344, 2);
    run_access("ld_h_hi", 1'b1, 1'b0, 2'b01, 32'h202, 32'h0,        32'hFFFF_8001, 1'b0, 4'b1111, 32'h0, 4);
    run_access("ld_h_lo", 1'b1, 1'b0, 2'b01, 32'h200, 32'h0,        32'h0000_1234, 1'b0, 4'b1111, 32'h0, 4);
    run_access("ld_b3",   1'b1, 1'b0, 2'b00, 32'h203, 32'h0,        32'hFFFF_FF80, 1'b0, 4'b1111, 32'h0, 4);
    run_access("ld_b1",   1'b1, 1'b0, 2'b00, 32'h201, 32'h0,        32'h0000_0012, 1'b0, 4'b1111, 32'h0, 4);
    run_access("ld_w",    1'b1, 1'b0, 2'b11, 32'h200, 32'h0,        32'h8001_1234, 1'b0, 4'b1111, 32'h0, 4);
    run_access("mis_w",   1'b1, 1'b0, 2'b10, 32'h302, 32'h0,        32'h0,         1'b1, 4'b1111, 32'h0, 1);
    run_access("mis_h",   1'b1, 1'b1, 2'b01, 32'h301, 32'h55,       32'h0,         1'b1, 4'b1111, 32'h0, 1);
    chk("mis.drdata_held", DRdata, 32'h8001_1234);

    // Contention: both requests held continuously.
    IReq = 1'b1; IAddr = 32'h1000;
    DReq = 1'b1; DWe = 1'b0; DSize = 2'b10; DAddr = 32'h2000;
    g = 0;
    for (int cyc = 0; cyc < 200 && g < 10; cyc++) begin
      @(negedge Clk);
      if (MemEn) begin
        grant_is_d[g] = (MemAddr == 32'h2000);
        g++;
      end
    end
    IReq = 1'b0; DReq = 1'b0;
    chk("contend.grants", g, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("contend.grant%0d", i), {31'd0, grant_is_d[i]}, (i % 5 == 4) ? 32'd0 : 32'd1);
    repeat (8) @(negedge Clk);

    // Reset in the first WAIT cycle of a load.
    DReq = 1'b1; DWe = 1'b0; DSize = 2'b10; DAddr = 32'h200;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1; DReq = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("rst_mid.outs", {IValid, DValid, DErr, MemEn, MemWe}, 5'd0);
    chk("rst_mid.byteen", MemByteEn, 4'b0000);
    chk("rst_mid.memaddr", MemAddr, 32'd0);
    chk("rst_mid.drdata", DRdata, 32'd0);
    chk("rst_mid.irdata", IRdata, 32'd0);
    n_valid = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge Clk);
      if (IValid || DValid || MemEn) n_valid++;
    end
    chk("rst_mid.quiet", n_valid, 0);
    run_access("after_rst", 1'b1, 1'b0, 2'b01, 32'h202, 32'h0, 32'hFFFF_8001, 1'b0, 4'b1111, 32'h0, 4);
    chk("sb.empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
